// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the synchronous RAM and presents
// one instruction at a time over a valid/ready handshake. Optional FETCH_CNT_EN adds fetch_count.
module cpu_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  start_pc,
    output logic [7:0]  mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  pc_out,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    input  logic        halt,
    output logic        halted,
`ifdef FETCH_CNT_EN
    output logic [15:0] fetch_count,
`endif
    output logic [1:0]  fsm_state
);

    // Handshake: a transfer happens on every rising edge where instr_valid and
    // instr_ready are both high; instr/pc_out hold steady while valid waits.
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pc;
    logic       handshake;

    assign handshake = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // halt outranks redirect; neither can leave HALTED, only rst can.
    always_comb begin
        state_next = state;
        if (state != S_HALTED) begin
            if (halt) begin
                state_next = S_HALTED;
            end else if (redirect) begin
                state_next = S_FETCH;
            end else begin
                case (state)
                    S_FETCH: state_next = S_WAIT;
                    S_WAIT:  state_next = S_HOLD;
                    S_HOLD:  state_next = instr_ready ? S_FETCH : S_HOLD;
                    default: state_next = state;
                endcase
            end
        end
    end

    always_comb begin
        mem_rd    = (state == S_FETCH) && !rst;
        mem_addr  = pc;
        halted    = (state == S_HALTED);
        fsm_state = state;
    end

    // A redirect during WAIT drops the returning RAM word: instr is only loaded
    // when WAIT completes undisturbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= start_pc;
            instr       <= 16'h0000;
            pc_out      <= 8'h00;
            instr_valid <= 1'b0;
        end else if (state != S_HALTED) begin
            if (halt) begin
                instr_valid <= 1'b0;
            end else if (redirect) begin
                pc          <= redirect_pc;
                instr_valid <= 1'b0;
            end else begin
                case (state)
                    S_WAIT: begin
                        instr       <= mem_rdata;
                        pc_out      <= pc;
                        pc          <= pc + 8'd1;
                        instr_valid <= 1'b1;
                    end
                    S_HOLD: begin
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef FETCH_CNT_EN
    // instr_valid is never high in HALTED, so the counter freezes there.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 16'h0000;
        end else if (handshake) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule
